// File: rtl/button_debouncer.sv
// Per-channel push-button conditioner: 2-FF synchronizer, polarity fix, stable-time FSM.
// Optional BUTTON_DEBOUNCER_TOGGLE_EN turns btn_level into a toggle latch driven by btn_press.
module button_debouncer #(
  parameter int N              = 2,
  parameter int STABLE_CYCLES  = 1000000,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic          REL_PIN = (BTN_ACTIVE_LOW != 0);
  localparam logic [CW-1:0] LAST    = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, ARMING, PRESSED, DISARMING} state_t;

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] s;

  // Synchronizers reset to the idle pin level so no press is seen coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {N{REL_PIN}};
      sync2 <= {N{REL_PIN}};
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ {N{REL_PIN}};

  for (genvar i = 0; i < N; i++) begin : g_chan
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic          press_nx;
    logic          release_nx;
    logic          press_q;
    logic          release_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= RELEASED;
        count     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nx;
        count     <= count_nx;
        press_q   <= press_nx;
        release_q <= release_nx;
      end
    end

    // Counting the final stable edge as the accepting one gives exactly STABLE_CYCLES samples.
    always_comb begin
      state_nx   = state;
      count_nx   = count;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      case (state)
        RELEASED: begin
          if (s[i]) begin
            state_nx = ARMING;
            count_nx = CW'(1);
          end
        end
        ARMING: begin
          if (!s[i]) begin
            state_nx = RELEASED;
            count_nx = '0;
          end else if (count >= LAST) begin
            state_nx = PRESSED;
            count_nx = '0;
            press_nx = 1'b1;
          end else begin
            count_nx = count + CW'(1);
          end
        end
        PRESSED: begin
          if (!s[i]) begin
            state_nx = DISARMING;
            count_nx = CW'(1);
          end
        end
        DISARMING: begin
          if (s[i]) begin
            state_nx = PRESSED;
            count_nx = '0;
          end else if (count >= LAST) begin
            state_nx   = RELEASED;
            count_nx   = '0;
            release_nx = 1'b1;
          end else begin
            count_nx = count + CW'(1);
          end
        end
        default: begin
          state_nx = RELEASED;
          count_nx = '0;
        end
      endcase
    end

    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        toggle_q <= 1'b0;
      end else if (press_nx) begin
        toggle_q <= ~toggle_q;
      end
    end

    assign btn_level[i] = toggle_q;
`else
    assign btn_level[i] = (state == PRESSED) || (state == DISARMING);
`endif
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer (N=2, STABLE_CYCLES=16, active-low pins).
// Expected btn_level follows the toggle model when BUTTON_DEBOUNCER_TOGGLE_EN is defined.
module tb_button_debouncer;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn_in;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  int total = 0;
  int bad   = 0;
  int press_cnt [2];
  int release_cnt [2];
  int both_cnt = 0;

  logic [1:0] deb;
  logic [1:0] tog;

  button_debouncer #(
    .N(2),
    .STABLE_CYCLES(16),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Pulse bookkeeping, sampled a few ns after each rising edge.
  always @(posedge clk) begin
    #5;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        press_cnt[i]   += int'(btn_press[i]);
        release_cnt[i] += int'(btn_release[i]);
        if (btn_press[i] && btn_release[i]) both_cnt++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] pins, input int cycles);
    btn_in = pins;
    step(cycles);
  endtask

  function automatic logic [1:0] expLevel();
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    return tog;
`else
    return deb;
`endif
  endfunction

  task automatic checkState(input string tag, input logic [1:0] press, input logic [1:0] rel);
    checkOutput({tag, "_level"}, 32'(btn_level), 32'(expLevel()));
    checkOutput({tag, "_press"}, 32'(btn_press), 32'(press));
    checkOutput({tag, "_release"}, 32'(btn_release), 32'(rel));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      press_cnt[i]   = 0;
      release_cnt[i] = 0;
    end
    deb    = 2'b00;
    tog    = 2'b00;
    rst_n  = 1'b0;
    btn_in = 2'b11;

    // Reset with buttons idle, then a long quiet run.
    step(3);
    checkState("reset", 2'b00, 2'b00);
    rst_n = 1'b1;
    step(40);
    checkState("idle40", 2'b00, 2'b00);
    checkOutput("idle_press_cnt", 32'(press_cnt[0] + press_cnt[1]), 0);
    checkOutput("idle_release_cnt", 32'(release_cnt[0] + release_cnt[1]), 0);

    // Clean press and release on channel 0.
    applyStimulus(2'b10, 17);
    checkState("p0_k16", 2'b00, 2'b00);
    step(1);
    deb = 2'b01; tog ^= 2'b01;
    checkState("p0_k17", 2'b01, 2'b00);
    step(1);
    checkState("p0_k18", 2'b00, 2'b00);
    step(5);
    checkOutput("p0_press_cnt", 32'(press_cnt[0]), 1);
    applyStimulus(2'b11, 17);
    checkState("r0_k16", 2'b00, 2'b00);
    step(1);
    deb = 2'b00;
    checkState("r0_k17", 2'b00, 2'b01);
    step(1);
    checkState("r0_k18", 2'b00, 2'b00);

    // Bouncing channel 1: only the final held level is accepted.
    applyStimulus(2'b01, 5);
    applyStimulus(2'b11, 3);
    applyStimulus(2'b01, 10);
    applyStimulus(2'b11, 2);
    checkOutput("bounce_no_press", 32'(press_cnt[1]), 0);
    applyStimulus(2'b01, 17);
    checkState("b1_k16", 2'b00, 2'b00);
    checkOutput("bounce_still_none", 32'(press_cnt[1]), 0);
    step(1);
    deb = 2'b10; tog ^= 2'b10;
    checkState("b1_k17", 2'b10, 2'b00);
    step(1);
    checkOutput("bounce_one_press", 32'(press_cnt[1]), 1);
    applyStimulus(2'b11, 18);
    deb = 2'b00;
    checkState("b1_release", 2'b00, 2'b10);
    step(2);

    // Both channels pressed on the same edge.
    applyStimulus(2'b00, 17);
    checkState("both_k16", 2'b00, 2'b00);
    step(1);
    deb = 2'b11; tog ^= 2'b11;
    checkState("both_k17", 2'b11, 2'b00);
    step(1);
    checkState("both_k18", 2'b00, 2'b00);
    applyStimulus(2'b11, 18);
    deb = 2'b00;
    checkState("both_release", 2'b00, 2'b11);
    step(2);

    // Three clean presses on channel 0.
    for (int n = 0; n < 3; n++) begin
      applyStimulus(2'b10, 18);
      deb = 2'b01; tog ^= 2'b01;
      checkState($sformatf("tp%0d_press", n), 2'b01, 2'b00);
      step(2);
      applyStimulus(2'b11, 18);
      deb = 2'b00;
      checkState($sformatf("tp%0d_release", n), 2'b00, 2'b01);
      step(2);
    end

    // Reset mid-count with channel 0 held down.
    applyStimulus(2'b10, 11);
    rst_n = 1'b0;
    #1;
    deb = 2'b00; tog = 2'b00;
    checkState("midrst", 2'b00, 2'b00);
    step(3);
    rst_n = 1'b1;
    step(17);
    checkState("postrst_k16", 2'b00, 2'b00);
    step(1);
    deb = 2'b01; tog ^= 2'b01;
    checkState("postrst_k17", 2'b01, 2'b00);
    step(1);
    checkState("postrst_k18", 2'b00, 2'b00);
    applyStimulus(2'b11, 20);
    deb = 2'b00;
    checkOutput("final_level", 32'(btn_level), 32'(expLevel()));

    checkOutput("press_cnt0", 32'(press_cnt[0]), 6);
    checkOutput("press_cnt1", 32'(press_cnt[1]), 2);
    checkOutput("release_cnt0", 32'(release_cnt[0]), 6);
    checkOutput("release_cnt1", 32'(release_cnt[1]), 2);
    checkOutput("press_and_release", 32'(both_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
